// File: rtl/tow_arena_if.sv
// Player/LED bundle for the tug-of-war core: tick enable and raw buttons in,
// LED drive and match status out.
interface tow_arena_if #(
  parameter int unsigned NUM_LEDS = 7,
  parameter int unsigned SW       = 2
);
  logic                en;
  logic                pbl;
  logic                pbr;
  logic [NUM_LEDS-1:0] led;
  logic [SW-1:0]       score_l;
  logic [SW-1:0]       score_r;
  logic [1:0]          winner;
  logic                match_over;

  modport master (
    output en, pbl, pbr,
    input  led, score_l, score_r, winner, match_over
  );

  modport slave (
    input  en, pbl, pbr,
    output led, score_l, score_r, winner, match_over
  );
endinterface

// File: rtl/tow_arena.sv
// Tug-of-war game core: synchronised push detection, one-hot rope marker,
// round wins with a blinking hold display, and best-of match scoring.
module tow_arena #(
  parameter int unsigned NUM_LEDS    = 7,
  parameter int unsigned WIN_ROUNDS  = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_TICKS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  tow_arena_if.slave  bus
);
  localparam int unsigned C  = (NUM_LEDS - 1) / 2;
  localparam int unsigned SW = $clog2(WIN_ROUNDS + 1);
  localparam int unsigned PW = $clog2(NUM_LEDS);
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0]       PosC     = PW'(C);
  localparam logic [PW-1:0]       PosMax   = PW'(NUM_LEDS - 1);
  localparam logic [HW-1:0]       HoldLast = HW'(HOLD_TICKS - 1);
  localparam logic [SW-1:0]       ScoreMax = SW'(WIN_ROUNDS);
  localparam logic [NUM_LEDS-1:0] LedOne   = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LedLeft  = {1'b1, {(NUM_LEDS-1){1'b0}}};

  typedef enum logic [1:0] {StReady, StPlay, StShow, StMatch} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_l_q, sync_l_d, sync_r_q, sync_r_d;
  logic                    prev_l_q, prev_l_d, prev_r_q, prev_r_d;
  logic                    push_l_q, push_l_d, push_r_q, push_r_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic                    blink_q, blink_d;
  logic [SW-1:0]           score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]              winner_q, winner_d;
  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic                    match_over_q, match_over_d;
  logic                    lvl_l, lvl_r;
  logic [SW-1:0]           won_score;

  always_comb begin
    sync_l_d  = {sync_l_q[SYNC_STAGES-2:0], bus.pbl};
    sync_r_d  = {sync_r_q[SYNC_STAGES-2:0], bus.pbr};
    lvl_l     = sync_l_q[SYNC_STAGES-1];
    lvl_r     = sync_r_q[SYNC_STAGES-1];
    prev_l_d  = lvl_l;
    prev_r_d  = lvl_r;
    push_l_d  = lvl_l & ~prev_l_q;
    push_r_d  = lvl_r & ~prev_r_q;

    state_d   = state_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    blink_d   = blink_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    won_score = (winner_q == 2'b01) ? score_l_q : score_r_q;

    unique case (state_q)
      StReady: begin
        pos_d = PosC;
        // A button still held from the previous round must be released first.
        if (!lvl_l && !lvl_r) state_d = StPlay;
      end
      StPlay: begin
        if (push_l_q && !push_r_q) begin
          if (pos_q == PosMax) begin
            score_l_d = score_l_q + 1'b1;
            winner_d  = 2'b01;
            state_d   = StShow;
            blink_d   = 1'b1;
            hold_d    = '0;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (push_r_q && !push_l_q) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + 1'b1;
            winner_d  = 2'b10;
            state_d   = StShow;
            blink_d   = 1'b1;
            hold_d    = '0;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      StShow: begin
        if (bus.en) begin
          blink_d = ~blink_q;
          hold_d  = hold_q + 1'b1;
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            blink_d = 1'b1;
            if (won_score == ScoreMax) begin
              state_d = StMatch;
            end else begin
              state_d = StReady;
              pos_d   = PosC;
            end
          end
        end
      end
      StMatch: ;
    endcase

    // LED and status are registered from next-state values so they track the FSM.
    led_d = '0;
    unique case (state_d)
      StReady, StPlay: led_d = LedOne << pos_d;
      StShow:          if (blink_d) led_d = (winner_d == 2'b01) ? LedLeft : LedOne;
      StMatch:         led_d = '1;
    endcase
    match_over_d = (state_d == StMatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReady;
      sync_l_q     <= '0;
      sync_r_q     <= '0;
      prev_l_q     <= 1'b0;
      prev_r_q     <= 1'b0;
      push_l_q     <= 1'b0;
      push_r_q     <= 1'b0;
      pos_q        <= PosC;
      hold_q       <= '0;
      blink_q      <= 1'b1;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= 2'b00;
      led_q        <= LedOne << C;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_l_q     <= sync_l_d;
      sync_r_q     <= sync_r_d;
      prev_l_q     <= prev_l_d;
      prev_r_q     <= prev_r_d;
      push_l_q     <= push_l_d;
      push_r_q     <= push_r_d;
      pos_q        <= pos_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      led_q        <= led_d;
      match_over_q <= match_over_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.winner     = winner_q;
  assign bus.match_over = match_over_q;
endmodule

// File: tb/tb_tow_arena.sv
// Scoreboard bench for tow_arena: a game-level model predicts the outputs after
// every edge; a monitor compares them against the DUT on the falling edge.
module tb_tow_arena;
  localparam int unsigned N    = 7;
  localparam int unsigned WIN  = 3;
  localparam int unsigned S    = 2;
  localparam int unsigned HOLD = 8;
  localparam int unsigned SW   = $clog2(WIN + 1);
  localparam int          C    = (N - 1) / 2;
  localparam int          MAXE = 20000;
  localparam int          OW   = N + 2 * SW + 3;

  localparam int PhReady = 0;
  localparam int PhPlay  = 1;
  localparam int PhShow  = 2;
  localparam int PhMatch = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tow_arena_if #(.NUM_LEDS(N), .SW(SW)) bus ();

  tow_arena #(
    .NUM_LEDS(N), .WIN_ROUNDS(WIN), .SYNC_STAGES(S), .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Raw button samples per edge index, used to derive level and push history.
  bit rl [0:MAXE];
  bit rr [0:MAXE];
  int t        = 0;
  int last_rst = 0;
  int phase    = PhReady;
  int pos      = C;
  int sl       = 0;
  int sr       = 0;
  int win      = 0;
  int ticks    = 0;

  logic [OW-1:0] exp_q[$];
  int  passed  = 0;
  int  total   = 0;
  bit  started = 0;

  // Synchronised level just after edge e: raw sample from S-1 edges earlier.
  function automatic bit lvl(input bit is_l, input int e);
    int idx;
    idx = e - int'(S) + 1;
    if (idx <= last_rst) return 1'b0;
    return is_l ? rl[idx] : rr[idx];
  endfunction

  function automatic bit push(input bit is_l, input int e);
    if (e <= last_rst) return 1'b0;
    return lvl(is_l, e - 1) && !lvl(is_l, e - 2);
  endfunction

  function automatic logic [OW-1:0] expect_vec();
    logic [N-1:0] led;
    led = '0;
    case (phase)
      PhReady, PhPlay: led[pos] = 1'b1;
      PhShow: if (ticks % 2 == 0) begin
        if (win == 1) led[N-1] = 1'b1;
        else          led[0]   = 1'b1;
      end
      default: led = '1;
    endcase
    return {led, SW'(sl), SW'(sr), 2'(win), phase == PhMatch};
  endfunction

  // Reference model: one update per rising edge.
  initial begin
    bit pl, pr, ll, lr;
    forever begin
      @(posedge clk);
      t++;
      if (rst) begin
        rl[t] = 1'b0; rr[t] = 1'b0; last_rst = t;
        phase = PhReady; pos = C; sl = 0; sr = 0; win = 0; ticks = 0;
      end else begin
        rl[t] = bus.pbl; rr[t] = bus.pbr;
        pl = push(1'b1, t - 1); pr = push(1'b0, t - 1);
        ll = lvl(1'b1, t - 1);  lr = lvl(1'b0, t - 1);
        case (phase)
          PhReady: begin
            pos = C;
            if (!ll && !lr) phase = PhPlay;
          end
          PhPlay: begin
            if (pl && !pr) begin
              if (pos == N - 1) begin sl++; win = 1; phase = PhShow; ticks = 0; end
              else pos++;
            end else if (pr && !pl) begin
              if (pos == 0) begin sr++; win = 2; phase = PhShow; ticks = 0; end
              else pos--;
            end
          end
          PhShow: if (bus.en) begin
            ticks++;
            if (ticks == HOLD) begin
              if (((win == 1) ? sl : sr) == WIN) phase = PhMatch;
              else begin phase = PhReady; pos = C; end
            end
          end
          default: ;
        endcase
      end
      exp_q.push_back(expect_vec());
      started = 1'b1;
    end
  end

  // Monitor: compare every cycle away from the active edge.
  initial begin
    logic [OW-1:0] got, e;
    forever begin
      @(negedge clk);
      if (started) begin
        total++;
        got = {bus.led, bus.score_l, bus.score_r, bus.winner, bus.match_over};
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty t=%0d got=%h required=expected entry", t, got);
        end else begin
          e = exp_q.pop_front();
          if (got === e) passed++;
          else $display("FAIL outputs t=%0d got led=%b sl=%0d sr=%0d win=%b mo=%b required led=%b sl=%0d sr=%0d win=%b mo=%b",
                        t, got[OW-1 -: N], got[2*SW+2 -: SW], got[SW+2 -: SW], got[2:1], got[0],
                        e[OW-1 -: N], e[2*SW+2 -: SW], e[SW+2 -: SW], e[2:1], e[0]);
        end
      end
    end
  end

  task automatic step(input bit l, input bit r, input bit en);
    bus.pbl = l; bus.pbr = r; bus.en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit left);
    repeat (3) step(left, !left, 1'b0);
    idle(4);
  endtask

  task automatic en_pulses(input int n);
    repeat (n) begin step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0); end
  endtask

  initial begin
    bus.pbl = 1'b0; bus.pbr = 1'b0; bus.en = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    // Held left button: one step only.
    repeat (20) step(1'b1, 1'b0, 1'b0);
    idle(5);
    press(1'b0);
    // Simultaneous presses cancel.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    idle(5);
    // Three left rounds to take the match, with stray en ticks during play.
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1);
      repeat (4) press(1'b1);
      en_pulses(HOLD);
      idle(3);
    end
    repeat (3) press(1'b1);
    repeat (2) press(1'b0);
    en_pulses(4);
    // Reset in the middle of a win display.
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(3);
    repeat (4) press(1'b1);
    en_pulses(3);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(3);
    // Right win with the button held across SHOW->READY.
    repeat (4) press(1'b0);
    repeat (HOLD) begin step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); end
    repeat (6) step(1'b0, 1'b1, 1'b0);
    idle(4);
    // Randomised play with occasional resets.
    repeat (700) begin
      bit l, r;
      int len;
      l   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 5);
      if ($urandom_range(0, 150) == 0) rst = 1'b1;
      repeat (len) step(l, r, $urandom_range(0, 2) == 0);
      rst = 1'b0;
      repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, $urandom_range(0, 2) == 0);
    end
    idle(3);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tow_arena.md
# tow_arena

Parametrised tug-of-war game core: synchronises and edge-detects both player push-buttons, moves a one-hot rope marker across `NUM_LEDS` LEDs, detects round wins, displays a blinking win indication, and keeps a best-of match score. It sits between the raw `pbl`/`pbr` pins and the LED pins. It is paced by the 500 Hz `clk` from `clk_div` and the single-cycle `slowen` pulse from `Div256`. Unlike the fixed 7-LED game, it generalises LED count and match length and adds multi-round scoring.

## Interface
- `NUM_LEDS`, 7, LED count; odd, ≥3; centre `C = (NUM_LEDS-1)/2`
- `WIN_ROUNDS`, 3, round wins needed to take the match; ≥1
- `SYNC_STAGES`, 2, synchroniser depth per button; ≥2
- `HOLD_TICKS`, 8, `en` pulses spent in the win display; ≥1
- `clk` in 1: system clock; all logic is on its rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: single-cycle tick enable (`slowen`); paces blink and hold
- `pbl` in 1: raw left push-button, asynchronous
- `pbr` in 1: raw right push-button, asynchronous
- `led` out `NUM_LEDS`: LED drive; bit `NUM_LEDS-1` is leftmost
- `score_l` out `SW`: left round wins; `SW = $clog2(WIN_ROUNDS+1)`
- `score_r` out `SW`: right round wins
- `winner` out 2: 00 none, 01 left, 10 right (last round/match winner)
- `match_over` out 1: high once either score reaches `WIN_ROUNDS`

## Operation
- Sync: each button passes through `SYNC_STAGES` flops, then a previous-value flop. Each rising edge of the synchronised level yields one registered push pulse, `push_l`/`push_r`. A held button produces exactly one pulse.
- Marker `pos`, range 0..`NUM_LEDS-1`:
  - left push: `pos+1`; right push: `pos-1`
  - `push_l` and `push_r` in the same cycle cancel; no movement and no win
- FSM states:
  - READY: `pos=C`; push pulses ignored. Go to PLAY once both synchronised levels are low.
  - PLAY: apply pushes.
    - A lone `push_l` with `pos==NUM_LEDS-1` is a left round win: `score_l++`, `winner=01`, go to SHOW.
    - A lone `push_r` with `pos==0` is a right round win: `score_r++`, `winner=10`, go to SHOW.
  - SHOW: blink flag starts at 1 and toggles on each `en`. A counter counts `en` pulses.
    - On the `HOLD_TICKS`-th pulse: if the winner's score equals `WIN_ROUNDS`, go to MATCH.
    - Otherwise go to READY, with `pos=C` and `winner` held.
  - MATCH: `match_over=1`; scores and `winner` frozen; pushes ignored. Exit only by `rst`.
- `led` (registered) by state:
  - READY/PLAY: one-hot at `pos`
  - SHOW: edge LED of the winning side (bit `NUM_LEDS-1` left, bit 0 right) when blink=1, else all zero
  - MATCH: all ones
- Scores never exceed `WIN_ROUNDS`; no wrap.
- `en` has no effect in READY, PLAY or MATCH.

## Timing
- Reset values:
  - `led` = one-hot bit `C`
  - `score_l=score_r=0`, `winner=00`, `match_over=0`
  - state READY; all sync/edge flops 0; blink=1; hold counter 0
- Push latency: if raw `pbl` is first sampled high at edge k, then `push_l` is high during cycle k+`SYNC_STAGES`, and `pos`/`led`/scores update at edge k+`SYNC_STAGES`+1.
- Raw pulses shorter than one clock may be missed; debounce is external.
- SHOW→READY/MATCH transition happens at the edge that samples the `HOLD_TICKS`-th `en` high.
- `rst` has priority at every edge, in any state including mid-SHOW and MATCH.
- A button held through SHOW→READY keeps the FSM in READY until it is released; this prevents a stale press from moving the marker.

## Test plan
- Reset, NUM_LEDS=7 → `led=7'b0001000`, scores 0, `winner=00`, `match_over=0`; release both buttons → state PLAY.
- Single `pbl` press held 20 cycles, SYNC_STAGES=2 → `led=7'b0010000` exactly 3 edges after the first sampled-high edge; no further movement while held.
- `pbl` and `pbr` asserted on the same edge → `led` stays `7'b0001000`, scores unchanged.
- Four separate left presses from centre → `led` steps through bits 4, 5, 6. The 4th press gives `score_l=1`, `winner=01`, and bit 6 blinking per `en`. After 8 `en` pulses → `led=7'b0001000`, READY.
- Left wins 3 rounds with WIN_ROUNDS=3 → after the third SHOW, `match_over=1`, `led=7'b1111111`, `score_l=3`; further presses change nothing.
- Assert `rst` during SHOW → next edge gives all outputs at reset values.
